phase_unwrap: RTL and testbench
===============================

PHASE_UNWRAP -- requirements
Module: phase_unwrap

Interface
REQ-001 SHALL have parameter ANGLE_W, default 16: width of the signed angle input, fixed-point with pi = 12868.
REQ-002 SHALL have parameter ACC_W, default 24: width of the signed unwrapped-phase accumulator.
REQ-003 SHALL have parameter WIN_LOG2, default 4: the frequency window is 2^WIN_LOG2 phase differences.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port val_i, input, 1 bit: angle_i is valid this cycle.
REQ-007 SHALL have port angle_i, input, ANGLE_W bits, signed: wrapped angle in [-12868, 12868] from the angle stage.
REQ-008 SHALL have port clr_i, input, 1 bit: restarts the sequence (clears history and accumulators).
REQ-009 SHALL have port unwrap_o, output, ACC_W bits, signed: unwrapped phase.
REQ-010 SHALL have port val_o, output, 1 bit: unwrap_o is valid.
REQ-011 SHALL have port freq_o, output, ANGLE_W bits, signed: mean phase difference over the window.
REQ-012 SHALL have port freq_val_o, output, 1 bit: one-cycle strobe that freq_o is valid.
REQ-013 SHALL have port ovf_o, output, 1 bit: sticky accumulator-saturation flag.

Function
REQ-014 SHALL implement a two-state FSM, S_FIRST (no previous sample) and S_RUN; the FSM leaves reset in S_FIRST.
REQ-015 SHALL, on val_i in S_FIRST: store angle_i as prev; set the accumulator to sign-extended angle_i; go to S_RUN; not count a window difference.
REQ-016 SHALL, on val_i in S_RUN, compute d = angle_i - prev at ANGLE_W+1 bits: d > 12868 gives d - 25736; d < -12868 gives d + 25736; otherwise d unchanged. Exactly +/-12868 is not wrapped.
REQ-017 SHALL, in S_RUN, add the wrapped d to the accumulator and update prev to angle_i.
REQ-018 SHALL assert val_o exactly 2 cycles after val_i (diff/wrap register stage, then accumulate register stage); bubbles in val_i pass through unchanged and all state is held while val_i = 0.
REQ-019 SHALL keep a window sum (ANGLE_W+WIN_LOG2 bits) and a counter of S_RUN differences. When the 2^WIN_LOG2-th difference is accumulated: freq_o = sum >>> WIN_LOG2 (arithmetic shift, truncation toward -inf); freq_val_o = 1 in the same cycle as that sample's val_o; sum and counter restart at zero.
REQ-020 SHALL hold freq_o between strobes; freq_val_o SHALL be high for exactly one cycle per window.
REQ-021 SHALL make clr_i take effect on the next edge: FSM to S_FIRST; accumulator, window sum, counter and ovf_o cleared; in-flight pipeline samples discarded (val_o low next 2 cycles except as below).
REQ-022 SHALL, when clr_i and val_i are high in the same cycle, treat that sample as the S_FIRST sample of the new sequence.

Reset
REQ-023 SHALL, on rst, clear to 0 on the next edge: unwrap_o, val_o, freq_o, freq_val_o, ovf_o, the pipeline valids, prev, the accumulator, the window sum and the counter; FSM to S_FIRST.
REQ-024 SHALL give rst priority over clr_i and val_i; a sample presented during rst is dropped.

Configuration
REQ-025 SHALL, with macro PHASE_UNWRAP_SAT_EN defined, saturate the accumulator to [-(2^(ACC_W-1)-1), 2^(ACC_W-1)-1] and set ovf_o sticky on the first clamp until rst or clr_i.
REQ-026 SHALL, without PHASE_UNWRAP_SAT_EN, wrap the accumulator modulo 2^ACC_W and tie ovf_o to 0.

Structure
REQ-027 SHALL place PI_FIX = 12868, TWO_PI_FIX = 25736 and the default widths in a shared package phase_pkg.
REQ-028 SHALL implement the difference wrap of REQ-016 in one sub-module, phase_wrap (combinational, ANGLE_W parameterised); the FSM, pipeline and accumulators stay in phase_unwrap.

Verification
REQ-029 SHALL cover: after rst, angles 0, 1000, ..., 16000 (17 samples, consecutive) -> unwrap_o 0, 1000, ..., 16000 at 2-cycle latency; one freq_val_o with freq_o = 1000.
REQ-030 SHALL cover: angles 12000 then -12000 -> d = 1736, unwrap_o = 13736; angles -12000 then 12000 -> unwrap_o = -13736.
REQ-031 SHALL cover: prev 0, angle -12868 -> d = -12868 (no wrap); prev -6434, angle 6434 -> d = +12868 (no wrap).
REQ-032 SHALL cover: with PHASE_UNWRAP_SAT_EN, steps of +12000 for 800 samples -> unwrap_o holds at 8388607 and ovf_o = 1; clr_i -> ovf_o = 0. Without the macro, the same stimulus wraps negative and ovf_o stays 0.
REQ-033 SHALL cover: val_i with 1-in-3 gaps -> values identical to the consecutive case; clr_i with val_i carrying 5000 -> unwrap_o = 5000, new window count starts at 0.
REQ-034 SHALL cover: rst asserted mid-window (after 7 diffs) -> all outputs 0 next cycle; the next sample is handled as S_FIRST.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared constants and types for the phase unwrapper: fixed-point pi (pi = 12868),
// default widths and the sequence-state encoding.
package phase_pkg;

  localparam int PI_FIX       = 12868;
  localparam int TWO_PI_FIX   = 25736;
  localparam int ANGLE_W_DEF  = 16;
  localparam int ACC_W_DEF    = 24;
  localparam int WIN_LOG2_DEF = 4;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/phase_wrap.sv
// Combinational phase-difference wrap: d = angle - prev folded into [-pi, +pi].
// Differences of exactly +/-pi are left as they are.
module phase_wrap
  import phase_pkg::*;
#(
  parameter int ANGLE_W = ANGLE_W_DEF
) (
  input  logic signed [ANGLE_W-1:0] angle_i,
  input  logic signed [ANGLE_W-1:0] prev_i,
  output logic signed [ANGLE_W:0]   d_o
);

  localparam logic signed [ANGLE_W:0] PI_S     = (ANGLE_W+1)'(PI_FIX);
  localparam logic signed [ANGLE_W:0] TWO_PI_S = (ANGLE_W+1)'(TWO_PI_FIX);

  logic signed [ANGLE_W:0] raw;

  always_comb begin
    raw = (ANGLE_W+1)'(angle_i) - (ANGLE_W+1)'(prev_i);
    if (raw > PI_S) begin
      d_o = raw - TWO_PI_S;
    end else if (raw < -PI_S) begin
      d_o = raw + TWO_PI_S;
    end else begin
      d_o = raw;
    end
  end

endmodule

// File: rtl/phase_unwrap.sv
// Phase unwrapper: wrap-corrected difference stage, accumulate stage, windowed mean frequency.
// Define PHASE_UNWRAP_SAT_EN to saturate the accumulator and raise the sticky ovf_o flag.
module phase_unwrap
  import phase_pkg::*;
#(
  parameter int ANGLE_W  = ANGLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      val_i,
  input  logic signed [ANGLE_W-1:0] angle_i,
  input  logic                      clr_i,
  output logic signed [ACC_W-1:0]   unwrap_o,
  output logic                      val_o,
  output logic signed [ANGLE_W-1:0] freq_o,
  output logic                      freq_val_o,
  output logic                      ovf_o
);

  localparam int SUM_W = ANGLE_W + WIN_LOG2;

  state_e state_q, state_d;
  logic   is_first;

  logic signed [ANGLE_W-1:0] prev_q, prev_d;
  logic signed [ANGLE_W:0]   wrap_d;

  logic                      vld_p0_q, vld_p0_d;
  logic                      first_p0_q, first_p0_d;
  logic signed [ANGLE_W:0]   d_p0_q, d_p0_d;
  logic signed [ANGLE_W-1:0] ang_p0_q, ang_p0_d;

  logic                      vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W:0]     acc_wide;
  logic signed [SUM_W-1:0]   sum_q, sum_d, sum_nxt;
  logic [WIN_LOG2-1:0]       cnt_q, cnt_d;
  logic signed [ANGLE_W-1:0] freq_q, freq_d;
  logic                      fval_q, fval_d;

`ifdef PHASE_UNWRAP_SAT_EN
  localparam logic signed [ACC_W:0] ACC_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});

  logic ovf_q, ovf_d;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
    if (x > ACC_MAX) begin
      return ACC_W'(ACC_MAX);
    end else if (x < -ACC_MAX) begin
      return ACC_W'(-ACC_MAX);
    end
    return ACC_W'(x);
  endfunction

  function automatic logic clamps(input logic signed [ACC_W:0] x);
    return (x > ACC_MAX) || (x < -ACC_MAX);
  endfunction
`endif

  phase_wrap #(
    .ANGLE_W (ANGLE_W)
  ) u_wrap (
    .angle_i (angle_i),
    .prev_i  (prev_q),
    .d_o     (wrap_d)
  );

  // Sequence FSM: state register, next state, outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (val_i) begin
      state_d = S_RUN;
    end else if (clr_i) begin
      state_d = S_FIRST;
    end
  end

  // A clear coinciding with a sample makes that sample the start of a new sequence
  always_comb begin
    is_first = clr_i || (state_q == S_FIRST);
  end

  // Stage p0: history update and wrapped difference
  always_comb begin
    prev_d     = prev_q;
    vld_p0_d   = val_i;
    first_p0_d = is_first;
    d_p0_d     = d_p0_q;
    ang_p0_d   = ang_p0_q;
    if (val_i) begin
      prev_d   = angle_i;
      d_p0_d   = wrap_d;
      ang_p0_d = angle_i;
    end
  end

  // Stage p1: accumulate, window sum, frequency strobe
  always_comb begin
    acc_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(d_p0_q);
    sum_nxt  = sum_q + SUM_W'(d_p0_q);
    vld_p1_d = vld_p0_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    fval_d   = 1'b0;
`ifdef PHASE_UNWRAP_SAT_EN
    ovf_d    = ovf_q;
`endif
    if (vld_p0_q) begin
      if (first_p0_q) begin
        acc_d = ACC_W'(ang_p0_q);
      end else begin
`ifdef PHASE_UNWRAP_SAT_EN
        acc_d = sat_acc(acc_wide);
        if (clamps(acc_wide)) begin
          ovf_d = 1'b1;
        end
`else
        acc_d = acc_wide[ACC_W-1:0];
`endif
        if (cnt_q == '1) begin
          freq_d = ANGLE_W'(sum_nxt >>> WIN_LOG2);
          fval_d = 1'b1;
          sum_d  = '0;
          cnt_d  = '0;
        end else begin
          sum_d  = sum_nxt;
          cnt_d  = cnt_q + 1'b1;
        end
      end
    end
    if (clr_i) begin
      vld_p1_d = 1'b0;
      acc_d    = '0;
      sum_d    = '0;
      cnt_d    = '0;
      fval_d   = 1'b0;
`ifdef PHASE_UNWRAP_SAT_EN
      ovf_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      vld_p0_q   <= 1'b0;
      first_p0_q <= 1'b0;
      d_p0_q     <= '0;
      ang_p0_q   <= '0;
      vld_p1_q   <= 1'b0;
      acc_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      freq_q     <= '0;
      fval_q     <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      vld_p0_q   <= vld_p0_d;
      first_p0_q <= first_p0_d;
      d_p0_q     <= d_p0_d;
      ang_p0_q   <= ang_p0_d;
      vld_p1_q   <= vld_p1_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      freq_q     <= freq_d;
      fval_q     <= fval_d;
    end
  end

`ifdef PHASE_UNWRAP_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign unwrap_o   = acc_q;
  assign val_o      = vld_p1_q;
  assign freq_o     = freq_q;
  assign freq_val_o = fval_q;

endmodule

// File: tb/tb_phase_unwrap.sv
// Scoreboard bench for phase_unwrap: directed angle sequences with hand-derived results.
// Expectations follow PHASE_UNWRAP_SAT_EN when it is defined for the build.
module tb_phase_unwrap;
  import phase_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               val_i;
  logic signed [15:0] angle_i;
  logic               clr_i;
  logic signed [23:0] unwrap_o;
  logic               val_o;
  logic signed [15:0] freq_o;
  logic               freq_val_o;
  logic               ovf_o;

  phase_unwrap #(
    .ANGLE_W  (16),
    .ACC_W    (24),
    .WIN_LOG2 (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .val_i      (val_i),
    .angle_i    (angle_i),
    .clr_i      (clr_i),
    .unwrap_o   (unwrap_o),
    .val_o      (val_o),
    .freq_o     (freq_o),
    .freq_val_o (freq_val_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int u;
    bit fv;
    int f;
    bit ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   held_f = 0;
  bit   cur_ovf = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send(input int a, input bit c, input int eu, input bit efv, input int ef);
    exp_t e;
    val_i   = 1'b1;
    angle_i = 16'(a);
    clr_i   = c;
    if (efv) held_f = ef;
    e.u   = eu;
    e.fv  = efv;
    e.f   = held_f;
    e.ovf = cur_ovf;
    q.push_back(e);
    @(posedge clk);
    #1;
    val_i = 1'b0;
    clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " unwrap_o"}, unwrap_o, 0);
    chk({tag, " val_o"}, val_o, 0);
    chk({tag, " freq_o"}, freq_o, 0);
    chk({tag, " freq_val_o"}, freq_val_o, 0);
    chk({tag, " ovf_o"}, ovf_o, 0);
  endtask

  always @(negedge clk) begin
    if (val_o) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected val_o: unwrap_o=%0d with no pending expectation", unwrap_o);
      end else begin
        mon_e = q.pop_front();
        chk("unwrap_o", unwrap_o, mon_e.u);
        chk("freq_val_o", freq_val_o, mon_e.fv);
        chk("freq_o", freq_o, mon_e.f);
        chk("ovf_o", ovf_o, mon_e.ovf);
      end
    end else if (freq_val_o) begin
      total++;
      bad++;
      $display("FAIL freq_val_o without val_o: freq_o=%0d", freq_o);
    end
  end

  initial begin
    longint             t;
    logic signed [23:0] w;
    int                 ang;
    int                 eu;

    rst     = 1'b1;
    val_i   = 1'b0;
    clr_i   = 1'b0;
    angle_i = '0;
    idle(3);
    rst = 1'b0;
    check_zero("reset");

    // consecutive ramp straight out of reset
    for (int i = 0; i <= 16; i++) send(1000 * i, 1'b0, 1000 * i, i == 16, 1000);
    idle(4);

    // same ramp with bubbles after every second sample
    send(0, 1'b1, 0, 1'b0, 0);
    for (int i = 1; i <= 16; i++) begin
      send(1000 * i, 1'b0, 1000 * i, i == 16, 1000);
      if (i % 2 == 0) idle(1);
    end
    idle(4);

    // wrap across +/-pi and the exact +/-pi boundaries
    send(12000, 1'b1, 12000, 1'b0, 0);
    send(-12000, 1'b0, 13736, 1'b0, 0);
    idle(3);
    send(-12000, 1'b1, -12000, 1'b0, 0);
    send(12000, 1'b0, -13736, 1'b0, 0);
    idle(3);
    send(0, 1'b1, 0, 1'b0, 0);
    send(-12868, 1'b0, -12868, 1'b0, 0);
    idle(3);
    send(-6434, 1'b1, -6434, 1'b0, 0);
    send(6434, 1'b0, 6434, 1'b0, 0);
    idle(4);

    // clear with a sample: in-flight sample dropped, window restarts
    send(0, 1'b1, 0, 1'b0, 0);
    send(100, 1'b0, 100, 1'b0, 0);
    send(200, 1'b0, 200, 1'b0, 0);
    send(300, 1'b0, 300, 1'b0, 0);
    void'(q.pop_back());
    send(5000, 1'b1, 5000, 1'b0, 0);
    for (int k = 1; k <= 16; k++) send(5000 + 100 * k, 1'b0, 5000 + 100 * k, k == 16, 100);
    idle(4);

    // long +12000 staircase to drive the accumulator past full scale
    ang = 0;
    for (int i = 0; i < 800; i++) begin
      t = 64'(12000) * i;
`ifdef PHASE_UNWRAP_SAT_EN
      if (t > 64'(8388607)) begin
        eu      = 8388607;
        cur_ovf = 1'b1;
      end else begin
        eu = int'(t);
      end
`else
      w  = t[23:0];
      eu = w;
`endif
      send(ang, i == 0, eu, (i > 0) && (i % 16 == 0), 12000);
      ang = ang + 12000;
      if (ang > 12868) ang = ang - 25736;
    end
    idle(4);
    clr_i = 1'b1;
    idle(1);
    clr_i   = 1'b0;
    cur_ovf = 1'b0;
    chk("ovf_o after clr", ovf_o, 0);
    chk("freq_o held across clr", freq_o, 12000);
    idle(3);

    // reset in the middle of a window
    send(0, 1'b1, 0, 1'b0, 0);
    for (int k = 1; k <= 7; k++) send(50 * k, 1'b0, 50 * k, 1'b0, 0);
    void'(q.pop_back());
    rst = 1'b1;
    idle(1);
    rst    = 1'b0;
    held_f = 0;
    check_zero("mid-window reset");
    send(7000, 1'b0, 7000, 1'b0, 0);
    for (int k = 1; k <= 16; k++) send(7000 + 100 * k, 1'b0, 7000 + 100 * k, k == 16, 100);

    idle(10);
    chk("pending expectations", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
